// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one ALU between two requesters.
// Operands are registered into the ALU, and the result and flags come back on a tagged response channel.
module alu_scheduler #(
  parameter int DW   = 8,
  parameter int SW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [SW-1:0]   req0_shift,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [SW-1:0]   req1_shift,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_s,
  output logic [SW-1:0]   alu_shift,
  input  logic [DW-1:0]   alu_y,
  input  logic            alu_cero,
  input  logic            alu_carry,
  input  logic            alu_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_y,
  output logic            rsp_zero,
  output logic            rsp_carry,
  output logic            rsp_ovf,
  output logic            rsp_err,
  output logic            busy,
  output logic [CNTW-1:0] ops_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  logic   rr;      // 0: port 0 wins a tie, 1: port 1 wins a tie
  logic   grant1;
  logic   illegal;

  always_comb begin
    grant1 = req1_valid && (!req0_valid || rr);
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant1;
  assign req1_ready = (state == IDLE) && grant1;
  assign busy       = (state != IDLE);
  assign illegal    = alu_s[2] && alu_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      alu_shift <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
      ops_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a     <= req0_a;
            alu_b     <= req0_b;
            alu_s     <= req0_op;
            alu_shift <= req0_shift;
            rsp_id    <= 1'b0;
            rr        <= 1'b1;
            state     <= EXEC;
          end else if (req1_ready) begin
            alu_a     <= req1_a;
            alu_b     <= req1_b;
            alu_s     <= req1_op;
            alu_shift <= req1_shift;
            rsp_id    <= 1'b1;
            rr        <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // ALU output has settled on the registered operands by this edge
          if (illegal) begin
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b1;
          end else begin
            rsp_y     <= alu_y;
            rsp_zero  <= alu_cero;
            rsp_carry <= alu_carry;
            rsp_ovf   <= alu_ovf;
            rsp_err   <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_count <= ops_count + CNTW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler, with a behavioural ALU attached to the alu_* ports.
// It uses a vector table for single operations and hand-written sequences for arbitration, backpressure and reset.
module tb_alu_scheduler;
  localparam int DW = 8, SW = 4, CNTW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SW-1:0] req0_shift, req1_shift;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_s;
  logic [SW-1:0] alu_shift;
  logic alu_cero, alu_carry, alu_ovf;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_ovf, rsp_err, busy;
  logic [DW-1:0] rsp_y;
  logic [CNTW-1:0] ops_count;

  alu_scheduler #(.DW(DW), .SW(SW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_shift(alu_shift),
    .alu_y(alu_y), .alu_cero(alu_cero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .busy(busy), .ops_count(ops_count)
  );

  // Behavioural ALU; illegal opcodes return junk that the scheduler must suppress
  logic [DW:0] add_w, sub_w;
  logic [DW-1:0] sum8, m_y;
  logic m_z, m_c, m_v;
  assign add_w = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_w = {1'b0, alu_a} - {1'b0, alu_b};
  assign sum8  = alu_a + alu_b;
  always_comb begin
    m_y = '0; m_c = 1'b0; m_v = 1'b0;
    case (alu_s)
      3'd0: begin m_y = add_w[DW-1:0]; m_c = add_w[DW];
                  m_v = (alu_a[7] == alu_b[7]) && (m_y[7] != alu_a[7]); end
      3'd1: begin m_y = sub_w[DW-1:0]; m_c = sub_w[DW];
                  m_v = (alu_a[7] != alu_b[7]) && (m_y[7] != alu_a[7]); end
      3'd2: m_y = alu_a & alu_b;
      3'd3: m_y = alu_a | alu_b;
      3'd4: m_y = sum8 << alu_shift;
      3'd5: m_y = sum8 >> alu_shift;
      default: begin m_y = 8'hFF; m_c = 1'b1; m_v = 1'b1; end
    endcase
    m_z = (alu_s[2] && alu_s[1]) ? 1'b1 : (m_y == '0);
  end
  assign alu_y = m_y;
  assign alu_cero = m_z;
  assign alu_carry = m_c;
  assign alu_ovf = m_v;

  typedef struct {
    logic id; logic [2:0] op; logic [7:0] a, b; logic [3:0] sh;
    logic [7:0] y; logic z, c, v, e;
  } vec_t;
  vec_t vecs[11];

  int n_chk = 0, n_fail = 0;
  int unsigned exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] sh);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_shift = sh; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_shift = sh; end
  endtask

  task automatic run_vec(input vec_t t);
    logic rdy, other;
    @(negedge clk);
    drive(t.id, 1'b1, t.op, t.a, t.b, t.sh);
    drive(!t.id, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    for (int k = 0; k < 10; k++) begin
      #1;
      rdy = t.id ? req1_ready : req0_ready;
      if (rdy) break;
      @(negedge clk);
    end
    other = t.id ? req0_ready : req1_ready;
    chk("req_ready", {31'd0, rdy}, 32'd1);
    chk("other_ready", {31'd0, other}, 32'd0);
    @(posedge clk); #1;
    drive(t.id, 1'b0, t.op, t.a, t.b, t.sh);
    @(negedge clk);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("alu_operands", {9'd0, alu_s, alu_shift, alu_a, alu_b}, {9'd0, t.op, t.sh, t.a, t.b});
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, t.id});
    chk("rsp_y", {24'd0, rsp_y}, {24'd0, t.y});
    chk("rsp_flags_zcve", {28'd0, rsp_zero, rsp_carry, rsp_ovf, rsp_err},
        {28'd0, t.z, t.c, t.v, t.e});
    @(posedge clk); #1;
    exp_count++;
    @(negedge clk);
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("ops_count", {16'd0, ops_count}, exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    bit dropped;
    vecs[0]  = '{1'b0, 3'd0, 8'h7F, 8'h01, 4'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'd1, 8'h05, 8'h05, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 8'hF0, 8'h3C, 4'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd3, 8'hA0, 8'h05, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd4, 8'h03, 8'h04, 4'd2, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd5, 8'hF0, 8'h20, 4'd3, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 8'h80, 8'h01, 4'd0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd1, 8'h01, 8'h02, 4'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd6, 8'h12, 8'h34, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 3'd7, 8'h00, 8'h00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset_alu", {9'd0, alu_s, alu_shift, alu_a, alu_b}, 32'd0);
    chk("reset_rsp", {21'd0, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf, rsp_err}, 32'd0);
    chk("reset_busy_count", {15'd0, busy, ops_count}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both ports continuously valid: grants alternate, one op per 3 cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 8'h01, 8'h02, 4'd0);
    drive(1'b1, 1'b1, 3'd3, 8'h0F, 8'hF0, 4'd0);
    dropped = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (g_id.size() == 4 && !dropped) begin
        drive(1'b0, 1'b0, 3'd0, 8'h01, 8'h02, 4'd0);
        drive(1'b1, 1'b0, 3'd3, 8'h0F, 8'hF0, 4'd0);
        dropped = 1;
      end else if (req0_ready || req1_ready) begin
        g_id.push_back(int'(req1_ready));
        g_cyc.push_back(cyc);
      end
      if (rsp_valid) begin
        r_id.push_back(int'(rsp_id));
        chk("rr_rsp_y", {24'd0, rsp_y}, rsp_id ? 32'hFF : 32'h03);
      end
      if (r_id.size() == 4) break;
      @(negedge clk);
    end
    chk("rr_grants", g_id.size(), 4);
    chk("rr_responses", r_id.size(), 4);
    for (int i = 0; i < 4 && i < g_id.size() && i < r_id.size(); i++) begin
      chk("rr_grant_order", g_id[i], i % 2);
      chk("rr_rsp_order", r_id[i], i % 2);
      if (i > 0) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end
    @(posedge clk); #1;
    exp_count += 4;
    @(negedge clk);
    chk("rr_ops_count", {16'd0, ops_count}, exp_count);

    // Backpressure: response held stable, no new grants while stalled
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 8'h10, 8'h20, 4'd0);
    #1 chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd2, 8'hAA, 8'h55, 4'd0);
    drive(1'b1, 1'b1, 3'd3, 8'hAA, 8'h55, 4'd0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp", {22'd0, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf, rsp_err},
          {22'd0, 1'b1, 1'b0, 8'h30, 4'b0000});
      chk("bp_busy_ready", {29'd0, busy, req0_ready, req1_ready}, 32'd4);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);
    @(negedge clk);
    exp_count++;
    chk("bp_done", {15'd0, rsp_valid, ops_count}, exp_count);

    // Reset asserted while a response is pending
    rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 4'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 8'h01, 8'h01, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_valid", {31'd0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort", {14'd0, rsp_valid, busy, ops_count}, 32'd0);
    chk("rst_abort_data", {23'd0, rsp_id, rsp_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 3'd1, 8'h09, 8'h04, 4'd0);
    drive(1'b1, 1'b1, 3'd0, 8'h09, 8'h04, 4'd0);
    #1 chk("rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd1, 8'h09, 8'h04, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 8'h09, 8'h04, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_next_rsp", {22'd0, rsp_valid, rsp_id, rsp_y}, {22'd0, 1'b1, 1'b0, 8'h05});
    @(posedge clk); #1;
    exp_count++;
    @(negedge clk);
    chk("rst_next_count", {16'd0, ops_count}, exp_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Round-robin scheduler sharing one 8-bit ALU instance between two requesters (port 0, port 1).
- Each requester issues an operation over a valid/ready handshake. The scheduler registers the operands, drives the ALU, and captures the result and flags (zero, carry, overflow).
- The result is returned on a shared response channel tagged with the requester ID.
- Sits between client logic and the ALU datapath. It is the only driver of the ALU inputs.

Parameters:
- DW, 8, operand/result width; must match the ALU.
- SW, 4, shift-amount width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_op  input  3  ALU opcode.
- req0_a  input  DW  operand A.
- req0_b  input  DW  operand B.
- req0_shift  input  SW  shift amount.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_shift: same as port 0, for port 1.
- alu_a  output  DW  ALU operand A, registered.
- alu_b  output  DW  ALU operand B, registered.
- alu_s  output  3  ALU opcode, registered.
- alu_shift  output  SW  ALU shift amount, registered.
- alu_y  input  DW  ALU result.
- alu_cero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- alu_ovf  input  1  ALU overflow flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  ID of the requester that owns the response.
- rsp_y  output  DW  result.
- rsp_zero  output  1  zero flag.
- rsp_carry  output  1  carry flag.
- rsp_ovf  output  1  overflow flag.
- rsp_err  output  1  illegal opcode.
- busy  output  1  FSM not in IDLE.
- ops_count  output  CNTW  number of completed responses.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All alu_* outputs 0.
  - All rsp_* outputs 0.
  - busy 0, ops_count 0.
  - Round-robin pointer favours port 0.
  - An assertion mid-operation aborts the operation immediately; the in-flight response is discarded.
- Opcodes:
  - 000 add, 001 sub, 010 and, 011 or, 100 (A+B) shifted left, 101 (A+B) shifted right.
  - 110 and 111 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational: 1 only for the granted port, and only in IDLE.
  - Grant rule: if exactly one port is valid, grant it. If both are valid, grant the port indicated by the RR pointer.
  - On handshake: latch op/a/b/shift into the alu_* registers, latch the ID into rsp_id, toggle the RR pointer to favour the other port, go to EXEC.
  - No request valid: stay in IDLE.
- EXEC (one cycle):
  - The ALU settles combinationally on the registered inputs.
  - At the clock edge: rsp_y←alu_y, rsp_zero←alu_cero, rsp_carry←alu_carry, rsp_ovf←alu_ovf, rsp_err←0, rsp_valid←1, go to RESP.
  - If the latched op is 110/111: rsp_y←0, all flags←0, rsp_err←1, rsp_valid←1.
- RESP:
  - All rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0. There is no timeout.
  - On rsp_valid&rsp_ready: rsp_valid←0, ops_count←ops_count+1 (wraps modulo 2^CNTW), go to IDLE.
  - Error responses also increment ops_count.
- alu_* registers hold their last value outside EXEC. They change only on an accepted request.
- Latency: request accepted at edge N → rsp_valid=1 after edge N+1.
- Throughput: one operation per 3 cycles when rsp_ready is held 1. There is no IDLE bypass.
- Requests arriving while busy wait; their ready stays 0. Requesters must hold valid and payload stable until ready.
- busy=1 in EXEC and RESP.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1,…
- Flags are passed through from the ALU unmodified. The scheduler performs no arithmetic.

Test Plan:
- Reset then single request, port 0: op=000, a=0x7F, b=0x01 → req0_ready=1 in IDLE; rsp_valid one cycle after accept; rsp_id=0, rsp_y=0x80, rsp_ovf=1, rsp_carry=0, rsp_zero=0; ops_count=1 after the handshake.
- Port 1 sub: op=001, a=0x05, b=0x05 → rsp_id=1, rsp_y=0x00, rsp_zero=1.
- Both ports valid continuously for 4 operations, rsp_ready=1 → grant order 0,1,0,1; one operation per 3 cycles; ops_count=4.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable; busy=1; req0_ready and req1_ready stay 0; completes on the first cycle with rsp_ready=1.
- Illegal opcode 110 on port 0 → rsp_err=1, rsp_y=0x00, all flags 0; ops_count increments.
- rst_n pulsed low during RESP → rsp_valid=0, busy=0, ops_count=0 immediately; next request after release is granted to port 0.
